// File: rtl/execute_md_pkg.sv
// Shared types for the execute stage with the M-extension unit.
// Macros: RVGA_XLEN64 selects a 64-bit datapath; RVGA_MD_DIV_EN enables the divider.
package execute_md_pkg;
`ifdef RVGA_XLEN64
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif
    localparam int SHW = $clog2(XLEN);

    typedef logic [XLEN-1:0] rvga_word;

    // bit 2 = divide family, bit 1 = remainder, bit 0 = unsigned (divide family)
    typedef enum logic [2:0] {
        MDOP_MUL, MDOP_MULH, MDOP_MULHSU, MDOP_MULHU,
        MDOP_DIV, MDOP_DIVU, MDOP_REM, MDOP_REMU
    } rvga_mdop;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
    } br_op_e;

    typedef struct packed {
        rvga_word pc;
        rvga_word rs1_data;
        rvga_word rs2_data;
        rvga_word imm;
        rvga_word rd_data;
        rvga_word jmp_tgt;
        alu_op_e  alu_op;
        br_op_e   br_op;
        logic     op1_sel;
        logic     op2_sel;
        logic     pcmux_sel;
        logic     md_enable;
        rvga_mdop mdop;
        logic     illegal;
        logic [4:0] rd_addr;
        logic     reg_we;
    } cword;

    localparam int CW_W = $bits(cword);

    function automatic rvga_word alu(alu_op_e op, rvga_word a, rvga_word b);
        rvga_word r;
        r = '0;
        case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_SLL:   r = a << b[SHW-1:0];
            ALU_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:   r = a ^ b;
            ALU_SRL:   r = a >> b[SHW-1:0];
            ALU_SRA:   r = rvga_word'($signed(a) >>> b[SHW-1:0]);
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(br_op_e op, rvga_word a, rvga_word b);
        logic t;
        t = 1'b0;
        case (op)
            BR_EQ:            t = (a == b);
            BR_NE:            t = (a != b);
            BR_LT:            t = ($signed(a) < $signed(b));
            BR_GE:            t = ($signed(a) >= $signed(b));
            BR_LTU:           t = (a < b);
            BR_GEU:           t = (a >= b);
            BR_JAL, BR_JALR:  t = 1'b1;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction
endpackage

// File: rtl/execute_md_md_unit.sv
// Multi-cycle multiply / restoring-divide unit with its own FSM.
// Divider state and datapath exist only when RVGA_MD_DIV_EN is defined.
module md_unit
    import execute_md_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            start_i,
    input  logic [2:0]      mdop_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2((XLEN > MUL_LAT) ? XLEN : MUL_LAT) + 1;

    md_state          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rvga_mdop         op_q, op_d;
    rvga_word         a_q, a_d, b_q, b_d, res_q, res_d;
    rvga_word         mul_res;
    logic [2*XLEN-1:0] prod;
    logic             a_sx, b_sx;

    always_comb begin
        a_sx = (op_q == MDOP_MULH || op_q == MDOP_MULHSU) & a_q[XLEN-1];
        b_sx = (op_q == MDOP_MULH) & b_q[XLEN-1];
        prod = {{XLEN{a_sx}}, a_q} * {{XLEN{b_sx}}, b_q};
        mul_res = (op_q == MDOP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

`ifdef RVGA_MD_DIV_EN
    rvga_word rem_q, rem_d, quo_nx, rem_nx, div_res;
    logic     nq_q, nq_d, nr_q, nr_d, qbit, sgn;
    logic [XLEN:0] rem_sh, diff;

    assign sgn = mdop_i[2] & ~mdop_i[0];

    // a_q doubles as the dividend/quotient shift register
    always_comb begin
        rem_sh  = {rem_q, a_q[XLEN-1]};
        diff    = rem_sh - {1'b0, b_q};
        qbit    = ~diff[XLEN];
        rem_nx  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx  = {a_q[XLEN-2:0], qbit};
        div_res = op_q[1] ? (nr_q ? -rem_nx : rem_nx) : (nq_q ? -quo_nx : quo_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            nq_q  <= 1'b0;
            nr_q  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            nq_q  <= nq_d;
            nr_q  <= nr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDOP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef RVGA_MD_DIV_EN
        rem_d   = rem_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
`endif
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    op_d = rvga_mdop'(mdop_i);
                    a_d  = a_i;
                    b_d  = b_i;
                    if (!mdop_i[2]) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
`ifdef RVGA_MD_DIV_EN
                    else begin
                        // operands become magnitudes; signs are reapplied on exit
                        a_d   = (sgn & a_i[XLEN-1]) ? -a_i : a_i;
                        b_d   = (sgn & b_i[XLEN-1]) ? -b_i : b_i;
                        rem_d = '0;
                        nq_d  = sgn & (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        nr_d  = sgn & a_i[XLEN-1];
                        if (b_i == '0) begin
                            state_d = ST_DONE;
                            res_d   = mdop_i[1] ? a_i : '1;
                        end else if (sgn && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1) begin
                            state_d = ST_DONE;
                            res_d   = mdop_i[1] ? '0 : a_i;
                        end else begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(XLEN - 1);
                        end
                    end
`endif
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        res_d   = mul_res;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef RVGA_MD_DIV_EN
                ST_DIV: begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        res_d   = div_res;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                ST_DONE: if (!stall_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == ST_MUL) | (state_q == ST_DIV) | ((state_q == ST_IDLE) & start_i);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = res_q;
endmodule

// File: rtl/execute_md.sv
// Execute stage: ALU/branch path plus the md_unit, feeding a registered ex_mem_cword.
// Without RVGA_MD_DIV_EN, divide/remainder ops retire in one cycle flagged illegal.
module execute_md
    import execute_md_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [CW_W-1:0] rf_ex_cword,
    output logic [CW_W-1:0] ex_mem_cword,
    output logic            ex_busy
);
    cword     in_c, alu_c, md_c, out_q, out_d, cw_q;
    rvga_word op1, op2, md_res;
    logic     md_ok, md_start, md_done, md_busy;

    assign in_c = cword'(rf_ex_cword);

`ifdef RVGA_MD_DIV_EN
    assign md_ok = 1'b1;
`else
    assign md_ok = ~in_c.mdop[2];
`endif
    // a new op arriving with flush is held off until the following cycle
    assign md_start = in_c.md_enable & md_ok & ~flush;

    md_unit #(.MUL_LAT(MUL_LAT)) u_md (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .stall_i  (stall),
        .start_i  (md_start),
        .mdop_i   (in_c.mdop),
        .a_i      (in_c.rs1_data),
        .b_i      (in_c.rs2_data),
        .done_o   (md_done),
        .busy_o   (md_busy),
        .result_o (md_res)
    );

    always_comb begin
        op1             = in_c.op1_sel ? in_c.pc : in_c.rs1_data;
        op2             = in_c.op2_sel ? in_c.imm : in_c.rs2_data;
        alu_c           = in_c;
        alu_c.rd_data   = alu(in_c.alu_op, op1, op2);
        alu_c.jmp_tgt   = (in_c.br_op == BR_JALR) ? ((in_c.rs1_data + in_c.imm) & ~rvga_word'(1))
                                                  : (in_c.pc + in_c.imm);
        alu_c.pcmux_sel = br_taken(in_c.br_op, in_c.rs1_data, in_c.rs2_data);
        if (in_c.br_op == BR_JAL || in_c.br_op == BR_JALR) alu_c.rd_data = in_c.pc + rvga_word'(4);
        if (in_c.md_enable) begin
            alu_c.rd_data   = '0;
            alu_c.illegal   = 1'b1;
            alu_c.pcmux_sel = 1'b0;
        end
    end

    always_comb begin
        md_c         = cw_q;
        md_c.rd_data = md_res;
        out_d        = out_q;
        if (flush) begin
            out_d = '0;
        end else if (!stall) begin
            if (md_done)      out_d = md_c;
            else if (md_busy) out_d = '0;
            else              out_d = alu_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            cw_q  <= '0;
        end else begin
            out_q <= out_d;
            if (md_start) cw_q <= in_c;
        end
    end

    assign ex_mem_cword = out_q;
    assign ex_busy      = md_busy;
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: spec-level model, per-cycle compare, literal pins.
module tb_execute_md;
    import execute_md_pkg::*;

    localparam int MUL_LAT = 2;
`ifdef RVGA_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, stall, flush;
    logic [CW_W-1:0] rf_ex_cword, ex_mem_cword;
    logic            ex_busy;

    cword exp_out;
    logic exp_busy, chk_en;
    int   total = 0, bad = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    execute_md #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .rf_ex_cword(rf_ex_cword), .ex_mem_cword(ex_mem_cword), .ex_busy(ex_busy)
    );

    task automatic check(input string nm, input logic [CW_W-1:0] act, input logic [CW_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        check("ex_mem_cword", ex_mem_cword, exp_out);
        check("ex_busy", CW_W'(ex_busy), CW_W'(exp_busy));
        if (ex_busy) busy_cnt++;
    end

    // ---------------- model ----------------
    function automatic rvga_word mul_model(rvga_mdop op, rvga_word a, rvga_word b);
        logic signed [XLEN:0]     ea, eb;
        logic signed [2*XLEN+1:0] p;
        ea = (op == MDOP_MULH || op == MDOP_MULHSU) ? $signed({a[XLEN-1], a}) : $signed({1'b0, a});
        eb = (op == MDOP_MULH) ? $signed({b[XLEN-1], b}) : $signed({1'b0, b});
        p  = ea * eb;
        return (op == MDOP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic rvga_word div_model(rvga_mdop op, rvga_word a, rvga_word b);
        rvga_word q, r, mn;
        mn = '0; mn[XLEN-1] = 1'b1;
        if (b == '0) begin
            q = '1; r = a;
        end else if (op == MDOP_DIV || op == MDOP_REM) begin
            if (a == mn && b == '1) begin q = a; r = '0; end
            else begin q = rvga_word'($signed(a) / $signed(b)); r = rvga_word'($signed(a) % $signed(b)); end
        end else begin
            q = a / b; r = a % b;
        end
        return (op == MDOP_REM || op == MDOP_REMU) ? r : q;
    endfunction

    function automatic cword model_word(cword cw);
        cword r;
        rvga_word o1, o2;
        int sh;
        r  = cw;
        o1 = cw.op1_sel ? cw.pc : cw.rs1_data;
        o2 = cw.op2_sel ? cw.imm : cw.rs2_data;
        sh = int'(o2 % XLEN);
        if (cw.md_enable && (cw.mdop < MDOP_DIV)) begin
            r.rd_data = mul_model(cw.mdop, cw.rs1_data, cw.rs2_data);
        end else if (cw.md_enable && DIV_EN) begin
            r.rd_data = div_model(cw.mdop, cw.rs1_data, cw.rs2_data);
        end else if (cw.md_enable) begin
            r.rd_data = '0; r.illegal = 1'b1; r.pcmux_sel = 1'b0; r.jmp_tgt = cw.pc + cw.imm;
        end else begin
            case (cw.alu_op)
                ALU_ADD:   r.rd_data = o1 + o2;
                ALU_SUB:   r.rd_data = o1 - o2;
                ALU_SLL:   r.rd_data = o1 << sh;
                ALU_SLT:   r.rd_data = ($signed(o1) < $signed(o2)) ? 1 : 0;
                ALU_SLTU:  r.rd_data = (o1 < o2) ? 1 : 0;
                ALU_XOR:   r.rd_data = o1 ^ o2;
                ALU_SRL:   r.rd_data = o1 >> sh;
                ALU_SRA:   r.rd_data = rvga_word'($signed(o1) >>> sh);
                ALU_OR:    r.rd_data = o1 | o2;
                ALU_AND:   r.rd_data = o1 & o2;
                default:   r.rd_data = o2;
            endcase
            case (cw.br_op)
                BR_EQ:   r.pcmux_sel = cw.rs1_data == cw.rs2_data;
                BR_NE:   r.pcmux_sel = cw.rs1_data != cw.rs2_data;
                BR_LT:   r.pcmux_sel = $signed(cw.rs1_data) < $signed(cw.rs2_data);
                BR_GE:   r.pcmux_sel = $signed(cw.rs1_data) >= $signed(cw.rs2_data);
                BR_LTU:  r.pcmux_sel = cw.rs1_data < cw.rs2_data;
                BR_GEU:  r.pcmux_sel = cw.rs1_data >= cw.rs2_data;
                BR_JAL, BR_JALR: r.pcmux_sel = 1'b1;
                default: r.pcmux_sel = 1'b0;
            endcase
            r.jmp_tgt = cw.pc + cw.imm;
            if (cw.br_op == BR_JALR) r.jmp_tgt = (cw.rs1_data + cw.imm) & ~rvga_word'(1);
            if (cw.br_op == BR_JAL || cw.br_op == BR_JALR) r.rd_data = cw.pc + 4;
        end
        return r;
    endfunction

    function automatic int latency(cword cw);
        rvga_word mn;
        mn = '0; mn[XLEN-1] = 1'b1;
        if (!cw.md_enable) return 1;
        if (cw.mdop < MDOP_DIV) return MUL_LAT + 2;
        if (!DIV_EN) return 1;
        if (cw.rs2_data == '0) return 2;
        if ((cw.mdop == MDOP_DIV || cw.mdop == MDOP_REM) && cw.rs1_data == mn && cw.rs2_data == '1) return 2;
        return XLEN + 2;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic cword mk_alu(alu_op_e op, rvga_word a, rvga_word b);
        cword c;
        c = '0; c.alu_op = op; c.rs1_data = a; c.rs2_data = b; c.rd_addr = 5'd3; c.reg_we = 1'b1;
        return c;
    endfunction

    function automatic cword mk_br(br_op_e br, rvga_word pc, rvga_word a, rvga_word b, rvga_word imm);
        cword c;
        c = '0; c.br_op = br; c.pc = pc; c.rs1_data = a; c.rs2_data = b; c.imm = imm;
        return c;
    endfunction

    function automatic cword mk_md(rvga_mdop op, rvga_word a, rvga_word b);
        cword c;
        c = mk_alu(ALU_ADD, a, b); c.md_enable = 1'b1; c.mdop = op;
        return c;
    endfunction

    // present cw until it retires; stall is held for cycles s_from..s_to (cycle n = after edge n)
    task automatic run_op(input cword cw, input int s_from, input int s_to);
        cword res;
        int   lat, c;
        bit   multi, written;
        res     = model_word(cw);
        lat     = latency(cw);
        multi   = (lat > 1);
        c       = 0;
        written = 0;
        rf_ex_cword = cw;
        stall    = (c >= s_from && c <= s_to);
        exp_busy = multi && (c < lat - 1);
        while (!written) begin
            @(posedge clk); #1;
            if (!stall) begin
                if (c + 1 >= lat) begin exp_out = res; written = 1; end
                else if (multi) exp_out = '0;
            end
            c++;
            if (written) begin
                rf_ex_cword = '0; stall = 1'b0; exp_busy = 1'b0;
            end else begin
                stall    = (c >= s_from && c <= s_to);
                exp_busy = multi && (c < lat - 1);
            end
            if (c > 300) begin
                bad++; total++;
                $display("FAIL run_op timeout: got no retirement want %0d edges", lat);
                written = 1;
            end
        end
    endtask

    task automatic flush_test();
        cword op;
        int   fc;
        if (DIV_EN) begin op = mk_md(MDOP_DIV, 100, 3); fc = 5; end
        else        begin op = mk_md(MDOP_MULHU, 100, 3); fc = 1; end
        rf_ex_cword = op; exp_busy = 1'b1;
        repeat (fc) begin @(posedge clk); #1; exp_out = '0; end
        flush = 1'b1; rf_ex_cword = '0;
        @(posedge clk); #1;
        flush = 1'b0; exp_out = '0; exp_busy = 1'b0;
        run_op(mk_alu(ALU_ADD, 5, 7), -1, -1);
    endtask

    cword     pin_c;
    rvga_word pin_w;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; rf_ex_cword = '0;
        exp_out = '0; exp_busy = 1'b0; chk_en = 1'b0;
        @(posedge clk); #1; chk_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // model pins
        pin_c = model_word(mk_alu(ALU_ADD, 5, 7));
        check("pin_add", CW_W'(pin_c.rd_data), CW_W'(32'd12));
        pin_w = mul_model(MDOP_MULH, 32'h8000_0000, 32'h8000_0000);
        check("pin_mulh", CW_W'(pin_w), CW_W'(32'h4000_0000));
        pin_w = mul_model(MDOP_MULHSU, 32'hFFFF_FFFF, 32'd2);
        check("pin_mulhsu", CW_W'(pin_w), CW_W'(32'hFFFF_FFFF));
        pin_w = div_model(MDOP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("pin_div", CW_W'(pin_w), CW_W'(32'hFFFF_FFFD));
        pin_w = div_model(MDOP_REM, 32'hFFFF_FFF9, 32'd2);
        check("pin_rem", CW_W'(pin_w), CW_W'(32'hFFFF_FFFF));
        pin_w = div_model(MDOP_DIVU, 32'd9, 32'd0);
        check("pin_divu0", CW_W'(pin_w), CW_W'(32'hFFFF_FFFF));
        pin_w = div_model(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("pin_ovf_q", CW_W'(pin_w), CW_W'(32'h8000_0000));
        pin_w = div_model(MDOP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        check("pin_ovf_r", CW_W'(pin_w), CW_W'(32'd0));

        // ALU / branch path
        run_op(mk_alu(ALU_ADD, 5, 7), -1, -1);
        pin_c = cword'(ex_mem_cword);
        check("add_rd", CW_W'(pin_c.rd_data), CW_W'(32'd12));
        run_op(mk_alu(ALU_SUB, 3, 5), -1, -1);
        run_op(mk_alu(ALU_SLT, 32'hFFFF_FFFF, 1), -1, -1);
        run_op(mk_alu(ALU_SRA, 32'h8000_0000, 4), -1, -1);
        run_op(mk_alu(ALU_OR, 32'hF0, 32'h0F), -1, -1);
        pin_c = mk_alu(ALU_ADD, 10, 0); pin_c.op2_sel = 1'b1; pin_c.imm = 32'hFFFF_FFFD;
        run_op(pin_c, -1, -1);
        run_op(mk_br(BR_EQ, 32'h100, 9, 9, 32'h20), -1, -1);
        run_op(mk_br(BR_NE, 32'h100, 9, 9, 32'h20), -1, -1);
        run_op(mk_br(BR_JAL, 32'h200, 0, 0, 32'h40), -1, -1);
        run_op(mk_br(BR_JALR, 32'h200, 32'h301, 0, 32'h4), -1, -1);

        // multiply
        run_op(mk_md(MDOP_MUL, 6, 7), -1, -1);
        busy_cnt = 0;
        run_op(mk_md(MDOP_MULH, 32'h8000_0000, 32'h8000_0000), -1, -1);
        pin_c = cword'(ex_mem_cword);
        check("mulh_rd", CW_W'(pin_c.rd_data), CW_W'(32'h4000_0000));
        check("mulh_busy_cycles", CW_W'(busy_cnt), CW_W'(3));
        run_op(mk_md(MDOP_MULHSU, 32'hFFFF_FFFF, 2), -1, -1);
        run_op(mk_md(MDOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), -1, -1);

        // divide family (illegal single-cycle ops when the divider is absent)
        run_op(mk_md(MDOP_DIV, 32'hFFFF_FFF9, 2), -1, -1);
`ifdef RVGA_MD_DIV_EN
        pin_c = cword'(ex_mem_cword);
        check("div_rd", CW_W'(pin_c.rd_data), CW_W'(32'hFFFF_FFFD));
`endif
        run_op(mk_md(MDOP_REM, 32'hFFFF_FFF9, 2), -1, -1);
        run_op(mk_md(MDOP_DIVU, 9, 0), -1, -1);
        run_op(mk_md(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), -1, -1);
        run_op(mk_md(MDOP_REM, 32'h8000_0000, 32'hFFFF_FFFF), -1, -1);
        run_op(mk_md(MDOP_REMU, 100, 7), -1, -1);
        run_op(mk_md(MDOP_DIVU, 32'hFFFF_FFFF, 3), -1, -1);

        // stall interaction
        run_op(mk_alu(ALU_XOR, 32'h55, 32'hFF), 0, 2);
        run_op(mk_md(MDOP_MUL, 32'h1234, 32'h10), 0, 1);
        run_op(mk_md(MDOP_DIVU, 1000, 10), 10, 40);
        run_op('0, -1, -1);
        run_op('0, -1, -1);

        // flush: mid-operation, and together with a new op
        flush_test();
        rf_ex_cword = mk_md(MDOP_MUL, 3, 4); flush = 1'b1; exp_busy = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; exp_out = '0;
        run_op(mk_md(MDOP_MUL, 3, 4), -1, -1);
        run_op('0, -1, -1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
